// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bru_pkg
// Description : Shared types for the branch resolve unit.
//               - bru_state_e : resolve/flush sequencer states.
//               - bru_ex_in_t : per-instruction control flags carried into EX.
//               The PC and target buses are not in this struct because their
//               width is a parameter of the top.
//               - bru_actual_taken : actual direction of a control-flow op.
// Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic valid;
        logic is_cond_br;
        logic is_jal;
        logic is_jalr;
        logic cond_true;
        logic predict_taken;
    } bru_ex_in_t;

    // Jumps are always taken; a conditional branch follows its ALU compare.
    function automatic logic bru_actual_taken(input bru_ex_in_t ex);
        return ex.is_jal | ex.is_jalr | (ex.is_cond_br & ex.cond_true);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//   clk    in   clock
//   arst_n in   synchronous active-low reset
//   inc    in   add one this cycle
//   count  out  current count (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : EX-stage branch resolution. Compares the fetch-side
//               prediction with the actual outcome, issues a one-cycle
//               redirect, sequences the wrong-path flush, sends a registered
//               training update to the BPU and keeps saturating counters.
//   clk, arst_n            clock, synchronous active-low reset
//   stall                  pipeline stall (freezes sequencer and flush count)
//   ex_*                   instruction in EX and its carried prediction
//   misprediction          one-cycle redirect pulse
//   redirect_pc            corrected fetch PC (valid with misprediction)
//   flush                  kill IF/ID this cycle
//   bpu_upd_*              one-cycle training update
//   branch_cnt             resolved control-flow instructions (saturating)
//   mispredict_cnt         mispredictions (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic                  ex_is_cond_br,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic                  ex_cond_true,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic                  ex_predict_taken,
    input  logic [DATA_WIDTH-1:0] ex_predict_pc,
    output logic                  misprediction,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  bpu_upd_valid,
    output logic [DATA_WIDTH-1:0] bpu_upd_pc,
    output logic                  bpu_upd_taken,
    output logic [DATA_WIDTH-1:0] bpu_upd_target,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // The pulse cycle is itself the first flush cycle, so the counter starts
    // one below FLUSH_CYCLES and exit happens on the unstalled cycle at zero.
    localparam logic [FCW-1:0] c_FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    bru_ex_in_t            w_ex;
    logic                  w_is_cf;
    logic                  w_act_taken;
    logic                  w_mis;
    logic [DATA_WIDTH-1:0] w_fix_pc;
    logic                  w_accept;
    logic                  w_hold_entry;
    logic                  w_hold_exit;
    logic                  w_inc_br;
    logic                  w_inc_mis;

    bru_state_e            r_state;
    logic [FCW-1:0]        r_fcnt;
    logic                  r_mispred;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic                  r_flush;
    logic                  r_upd_valid;
    logic [DATA_WIDTH-1:0] r_upd_pc;
    logic                  r_upd_taken;
    logic [DATA_WIDTH-1:0] r_upd_target;
    // Snapshot of a mispredicted instruction that arrived under stall.
    logic [DATA_WIDTH-1:0] r_hold_fix_pc;
    logic [DATA_WIDTH-1:0] r_hold_pc;
    logic                  r_hold_taken;
    logic [DATA_WIDTH-1:0] r_hold_target;

    assign w_ex = '{valid:         ex_valid,
                    is_cond_br:    ex_is_cond_br,
                    is_jal:        ex_is_jal,
                    is_jalr:       ex_is_jalr,
                    cond_true:     ex_cond_true,
                    predict_taken: ex_predict_taken};

    assign w_is_cf     = w_ex.valid & (w_ex.is_cond_br | w_ex.is_jal | w_ex.is_jalr);
    assign w_act_taken = bru_actual_taken(w_ex);
    // Direction mismatch, or both taken but to different targets.
    assign w_mis       = w_is_cf &
                         ((w_act_taken != w_ex.predict_taken) |
                          (w_act_taken & w_ex.predict_taken & (ex_target != ex_predict_pc)));
    assign w_fix_pc    = w_act_taken ? ex_target : (ex_pc + DATA_WIDTH'(4));

    assign w_accept     = (r_state == ST_IDLE) & ~stall & w_is_cf;
    assign w_hold_entry = (r_state == ST_IDLE) & stall & w_is_cf & w_mis;
    assign w_hold_exit  = (r_state == ST_HOLD) & ~stall;

    // Counters move on the same edge that raises bpu_upd_valid.
    assign w_inc_br  = w_accept | w_hold_exit;
    assign w_inc_mis = (w_accept & w_mis) | w_hold_exit;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state       <= ST_IDLE;
            r_fcnt        <= '0;
            r_mispred     <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_target  <= '0;
            r_hold_fix_pc <= '0;
            r_hold_pc     <= '0;
            r_hold_taken  <= 1'b0;
            r_hold_target <= '0;
        end else begin
            // Pulses last exactly one cycle regardless of stall.
            r_mispred   <= 1'b0;
            r_upd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_upd_valid  <= 1'b1;
                        r_upd_pc     <= ex_pc;
                        r_upd_taken  <= w_act_taken;
                        r_upd_target <= ex_target;
                        if (w_mis) begin
                            r_mispred     <= 1'b1;
                            r_redirect_pc <= w_fix_pc;
                            r_flush       <= 1'b1;
                            r_fcnt        <= c_FLUSH_LAST;
                            r_state       <= ST_FLUSH;
                        end
                    end else if (w_hold_entry) begin
                        r_hold_fix_pc <= w_fix_pc;
                        r_hold_pc     <= ex_pc;
                        r_hold_taken  <= w_act_taken;
                        r_hold_target <= ex_target;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_mispred     <= 1'b1;
                        r_redirect_pc <= r_hold_fix_pc;
                        r_flush       <= 1'b1;
                        r_upd_valid   <= 1'b1;
                        r_upd_pc      <= r_hold_pc;
                        r_upd_taken   <= r_hold_taken;
                        r_upd_target  <= r_hold_target;
                        r_fcnt        <= c_FLUSH_LAST;
                        r_state       <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Any instruction in EX here is wrong-path and ignored.
                    if (!stall) begin
                        if (r_fcnt == '0) begin
                            r_flush <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_fcnt <= r_fcnt - FCW'(1);
                        end
                    end
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_inc_br),
        .count  (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (w_inc_mis),
        .count  (mispredict_cnt)
    );

    assign misprediction  = r_mispred;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign bpu_upd_valid  = r_upd_valid;
    assign bpu_upd_pc     = r_upd_pc;
    assign bpu_upd_taken  = r_upd_taken;
    assign bpu_upd_target = r_upd_target;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Scoreboard bench for branch_resolve_unit. Stimulus pushes the
//               hand-computed training update it expects; a negedge monitor
//               pops and compares whenever bpu_upd_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          stall;
    logic          ex_valid, ex_is_cond_br, ex_is_jal, ex_is_jalr, ex_cond_true;
    logic [DW-1:0] ex_pc, ex_target, ex_predict_pc;
    logic          ex_predict_taken;
    logic          misprediction, flush, bpu_upd_valid, bpu_upd_taken;
    logic [DW-1:0] redirect_pc, bpu_upd_pc, bpu_upd_target;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    branch_resolve_unit #(.DATA_WIDTH(DW), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_is_cond_br    (ex_is_cond_br),
        .ex_is_jal        (ex_is_jal),
        .ex_is_jalr       (ex_is_jalr),
        .ex_cond_true     (ex_cond_true),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_predict_taken (ex_predict_taken),
        .ex_predict_pc    (ex_predict_pc),
        .misprediction    (misprediction),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .bpu_upd_valid    (bpu_upd_valid),
        .bpu_upd_pc       (bpu_upd_pc),
        .bpu_upd_taken    (bpu_upd_taken),
        .bpu_upd_target   (bpu_upd_target),
        .branch_cnt       (branch_cnt),
        .mispredict_cnt   (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pc;
        logic          taken;
        logic [DW-1:0] tgt;
        logic          mis;
        logic [DW-1:0] rpc;
    } exp_t;

    exp_t          q[$];
    int            n_total = 0;
    int            n_pass  = 0;
    logic [CW-1:0] m_br    = '0;
    logic [CW-1:0] m_mis   = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Monitor: every training update must match the oldest expectation.
    always @(negedge clk) begin
        if (bpu_upd_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_update", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("upd_pc", bpu_upd_pc, e.pc);
                chk("upd_taken", {31'd0, bpu_upd_taken}, {31'd0, e.taken});
                if (e.taken) chk("upd_target", bpu_upd_target, e.tgt);
                chk("mispred", {31'd0, misprediction}, {31'd0, e.mis});
                if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
            end
        end else if (misprediction) begin
            chk("pulse_without_update", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // Drive one instruction for one edge. When exp_acc is set the expected
    // update is queued and the reference counters advance.
    task automatic issue(input logic cb, input logic jal, input logic jalr, input logic ct,
                         input logic [DW-1:0] pc, input logic [DW-1:0] tgt,
                         input logic pt, input logic [DW-1:0] ppc,
                         input logic exp_acc, input logic exp_mis, input logic exp_taken,
                         input logic [DW-1:0] exp_rpc);
        exp_t e;
        ex_valid = 1'b1; ex_is_cond_br = cb; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_cond_true = ct; ex_pc = pc; ex_target = tgt;
        ex_predict_taken = pt; ex_predict_pc = ppc;
        if (exp_acc) begin
            e.pc = pc; e.taken = exp_taken; e.tgt = tgt; e.mis = exp_mis; e.rpc = exp_rpc;
            q.push_back(e);
            m_br = sat_inc(m_br);
            if (exp_mis) m_mis = sat_inc(m_mis);
        end
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_branch_cnt"}, {28'd0, branch_cnt}, {28'd0, m_br});
        chk({tag, "_mispredict_cnt"}, {28'd0, mispredict_cnt}, {28'd0, m_mis});
    endtask

    initial begin
        logic [CW-1:0] br_saved;
        arst_n = 1'b0; stall = 1'b0;
        ex_valid = 1'b0; ex_is_cond_br = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        ex_cond_true = 1'b0; ex_pc = '0; ex_target = '0;
        ex_predict_taken = 1'b0; ex_predict_pc = '0;
        idle(2);
        chk("rst_mispred", {31'd0, misprediction}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_upd_valid", {31'd0, bpu_upd_valid}, 32'd0);
        chk_cnts("rst");
        arst_n = 1'b1;
        idle(1);

        // Correctly predicted taken branch.
        issue(1,0,0,1, 32'h100, 32'h140, 1, 32'h140, 1, 0, 1, 32'h0);
        chk_cnts("t1");
        chk("t1_flush", {31'd0, flush}, 32'd0);

        // Predicted taken, actually not taken: redirect to pc+4, 2 flush cycles.
        issue(1,0,0,0, 32'h200, 32'h240, 1, 32'h240, 1, 1, 0, 32'h204);
        chk("t2_flush_c1", {31'd0, flush}, 32'd1);
        chk_cnts("t2");
        tick();
        chk("t2_flush_c2", {31'd0, flush}, 32'd1);
        tick();
        chk("t2_flush_end", {31'd0, flush}, 32'd0);

        // JALR target mismatch; wrong-path branch during FLUSH is ignored.
        issue(0,0,1,0, 32'h300, 32'h880, 1, 32'h800, 1, 1, 1, 32'h880);
        issue(1,0,0,1, 32'h400, 32'h480, 0, 32'h0, 0, 0, 0, 32'h0);
        idle(2);
        chk_cnts("t3");

        // Correct not-taken branch followed back-to-back by a correct JAL.
        issue(1,0,0,0, 32'h500, 32'h5F0, 0, 32'h0, 1, 0, 0, 32'h0);
        issue(0,1,0,0, 32'h600, 32'h700, 1, 32'h700, 1, 0, 1, 32'h0);
        chk_cnts("t3b");

        // Mispredict under a 3-cycle stall: held, then pulse with latched PC.
        br_saved = branch_cnt;
        stall = 1'b1;
        issue(1,0,0,1, 32'h900, 32'h9A0, 0, 32'h0, 1, 1, 1, 32'h9A0);
        ex_target = 32'hBAD0;
        idle(2);
        chk("t4_no_pulse", {31'd0, misprediction}, 32'd0);
        chk("t4_no_flush", {31'd0, flush}, 32'd0);
        chk("t4_cnt_frozen", {28'd0, branch_cnt}, {28'd0, br_saved});
        stall = 1'b0;
        tick();
        chk("t4_pulse", {31'd0, misprediction}, 32'd1);
        idle(3);
        chk_cnts("t4");

        // Fall-through wraps past the top of the address space.
        issue(1,0,0,0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 1, 1, 0, 32'h0000_0000);
        idle(3);

        // Drive mispredict count past 15; both counters must stick at 0xF.
        for (int i = 0; i < 12; i++) begin
            issue(1,0,0,1, 32'h1000 + 32'(i*16), 32'h2000, 0, 32'h0, 1, 1, 1, 32'h2000);
            idle(2);
        end
        chk_cnts("sat");
        chk("sat_mis_all_ones", {28'd0, mispredict_cnt}, 32'hF);

        // Reset for one cycle mid-FLUSH.
        issue(1,0,0,0, 32'h3000, 32'h3100, 1, 32'h3100, 1, 1, 0, 32'h3004);
        chk("t6_in_flush", {31'd0, flush}, 32'd1);
        arst_n = 1'b0;
        tick();
        m_br = '0; m_mis = '0;
        chk("t6_flush", {31'd0, flush}, 32'd0);
        chk("t6_mispred", {31'd0, misprediction}, 32'd0);
        chk("t6_upd_valid", {31'd0, bpu_upd_valid}, 32'd0);
        chk("t6_redirect", redirect_pc, 32'd0);
        chk("t6_upd_pc", bpu_upd_pc, 32'd0);
        chk_cnts("t6");
        arst_n = 1'b1;
        // IDLE immediately after reset: next branch is accepted.
        issue(1,0,0,1, 32'h4000, 32'h4040, 1, 32'h4040, 1, 0, 1, 32'h0);
        chk_cnts("t6_post");
        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage counterpart of the fetch-side branch predictor.
- Takes the prediction (predict_taken, predict_pc) carried down the pipe with each control-flow instruction and compares it with the actual outcome.
- Raises a one-cycle misprediction with a corrected redirect PC, and sequences the wrong-path flush.
- Sends a registered training update (pc, taken, target) to the BPU.
- Keeps saturating branch and mispredict performance counters.

Parameters:
DATA_WIDTH, 32, width of PC and target buses
FLUSH_CYCLES, 2, cycles of wrong-path kill after a redirect (IF and ID slots)
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  in  1  clock
arst_n  in  1  reset; synchronous, active-low (sampled on posedge clk only)
stall  in  1  pipeline stall; freezes the FSM and flush counter
ex_valid  in  1  EX holds a valid instruction
ex_is_cond_br  in  1  conditional branch
ex_is_jal  in  1  JAL
ex_is_jalr  in  1  JALR
ex_cond_true  in  1  ALU compare result for the conditional branch
ex_pc  in  DATA_WIDTH  PC of the EX instruction
ex_target  in  DATA_WIDTH  computed branch or jump target
ex_predict_taken  in  1  prediction carried from IF
ex_predict_pc  in  DATA_WIDTH  predicted target carried from IF
misprediction  out  1  one-cycle redirect pulse
redirect_pc  out  DATA_WIDTH  corrected fetch PC; valid when misprediction=1
flush  out  1  kill the IF/ID instructions this cycle
bpu_upd_valid  out  1  training update valid
bpu_upd_pc  out  DATA_WIDTH  PC of the resolved branch
bpu_upd_taken  out  1  actual direction
bpu_upd_target  out  DATA_WIDTH  actual target
branch_cnt  out  CNT_WIDTH  resolved control-flow instructions
mispredict_cnt  out  CNT_WIDTH  mispredictions

Behaviour:
- Reset: all outputs 0, state IDLE, flush counter 0, both performance counters 0. A reset mid-FLUSH or mid-HOLD aborts to IDLE with no pulse.
- Resolution (combinational, EX cycle):
  - is_cf = ex_valid & (ex_is_cond_br | ex_is_jal | ex_is_jalr).
  - act_taken = ex_is_jal | ex_is_jalr | (ex_is_cond_br & ex_cond_true).
  - mis = is_cf & ((act_taken != ex_predict_taken) | (act_taken & ex_predict_taken & (ex_target != ex_predict_pc))).
  - fix_pc = act_taken ? ex_target : ex_pc + 4, computed modulo 2^DATA_WIDTH (wraps).
- Resolution is accepted only when state is IDLE and stall=0. In FLUSH the instruction is wrong-path: it is ignored, with no update and no count.
- FSM states: IDLE, HOLD, FLUSH.
  - IDLE, accepted mis, stall=0: next cycle misprediction=1, redirect_pc=fix_pc, flush=1; go to FLUSH with cnt=FLUSH_CYCLES-1.
  - IDLE, is_cf & mis, stall=1: latch fix_pc; go to HOLD with no pulse.
  - HOLD: stay while stall=1. On stall=0, pulse misprediction with the latched PC, flush=1, go to FLUSH.
  - FLUSH: flush=1 each unstalled cycle. cnt decrements only when stall=0. When cnt=0 and stall=0, return to IDLE.
  - FLUSH_CYCLES=1: return to IDLE directly after the pulse cycle.
- misprediction is never high on two consecutive cycles. A second mispredict during HOLD or FLUSH is discarded.
- BPU update:
  - Registered, 1-cycle latency from each accepted is_cf (correct or mispredicted).
  - bpu_upd_valid is high for exactly one cycle per accepted is_cf.
  - It coincides with the misprediction pulse when mis=1.
  - When the instruction went to HOLD, the update is issued on the cycle of the pulse.
- Counters:
  - branch_cnt increments by 1 per accepted is_cf.
  - mispredict_cnt increments by 1 per accepted mis.
  - Both saturate at all-ones and do not wrap.
  - Both update on the same edge as bpu_upd_valid.

Decomposition:
- bru_pkg: state enum (IDLE, HOLD, FLUSH) and a bru_ex_in_t struct bundling the ex_* inputs. The ports may use the struct with the same field names.
- Sub-module sat_counter (parameter WIDTH; inputs clk, arst_n, inc; output count), instantiated twice for the performance counters.

Test Plan:
- Cond branch at ex_pc=0x100, cond_true=1, predict_taken=1, predict_pc=ex_target=0x140 -> no misprediction; next cycle bpu_upd_valid=1, taken=1, target=0x140; branch_cnt=1, mispredict_cnt=0.
- Cond branch at ex_pc=0x200, cond_true=0, predict_taken=1 -> next cycle misprediction=1, redirect_pc=0x204; flush high for 2 cycles; mispredict_cnt=1.
- JALR at ex_pc=0x300, ex_target=0x880, predict_taken=1, predict_pc=0x800 -> misprediction, redirect_pc=0x880. A valid branch in EX on the following cycle (FLUSH) is ignored: no update, no count.
- Mispredict with stall=1 held 3 cycles -> no pulse during the stall. Pulse and update occur on the first cycle after stall drops, with redirect_pc equal to the value latched at entry.
- ex_pc=0xFFFF_FFFC, not-taken, predicted taken -> redirect_pc=0x0000_0000.
- Preload mispredict_cnt to all-ones via forced mispredicts at CNT_WIDTH=4 (16 mispredicts) -> count stays 0xF. Drive arst_n=0 for 1 cycle mid-FLUSH -> all outputs 0 and state IDLE on the next edge.
